// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic multiplier slice (feeder, array, collector).
// Holds default dimensions, the feeder state encoding and the lane-select helper.
package systolic_pkg;

    localparam int unsigned DEF_DATA_WIDTH = 32;
    localparam int unsigned DEF_N          = 4;
    // Length of the skewed feed window: the last lane starts N-1 cycles late.
    localparam int unsigned FEED_LEN       = 2 * DEF_N - 1;

    typedef enum logic [2:0] {
        StLoadA,
        StLoadB,
        StClear,
        StFeed,
        StDone
    } feeder_state_e;

    // True when lane `lane` has a real element at skew step k, i.e. 0 <= k-lane < n.
    function automatic logic lane_hit(input int k, input int lane, input int n);
        return (k >= lane) && ((k - lane) < n);
    endfunction

endpackage

// File: rtl/systolic_feeder_if.sv
// Row-beat input handshake plus the skewed operand outputs of the feeder.
// slave  : feeder side (accepts beats, drives array edges and job strobes).
// master : producer/consumer side.
//   in_valid_i/in_ready_o/in_data_i : one matrix row per beat
//   clear_o, valid_o, feed_done_o, busy_o : job strobes and status
//   left_o, up_o : per-lane operands for array rows / columns
interface systolic_feeder_if #(
    parameter int unsigned DATA_WIDTH = systolic_pkg::DEF_DATA_WIDTH,
    parameter int unsigned N          = systolic_pkg::DEF_N
);
    logic                    in_valid_i;
    logic                    in_ready_o;
    logic [N*DATA_WIDTH-1:0] in_data_i;
    logic                    clear_o;
    logic                    valid_o;
    logic [N*DATA_WIDTH-1:0] left_o;
    logic [N*DATA_WIDTH-1:0] up_o;
    logic                    feed_done_o;
    logic                    busy_o;

    modport slave (
        input  in_valid_i, in_data_i,
        output in_ready_o, clear_o, valid_o, left_o, up_o, feed_done_o, busy_o
    );

    modport master (
        output in_valid_i, in_data_i,
        input  in_ready_o, clear_o, valid_o, left_o, up_o, feed_done_o, busy_o
    );
endinterface

// File: rtl/systolic_lane_sel.sv
// Picks one lane's operand for skew step k from a stored row or column vector.
//   vec_i  : N elements, element i in bits [i*DATA_WIDTH +: DATA_WIDTH]
//   lane_i : lane index (row for left lanes, column for top lanes)
//   k_i    : skew step of the feed window
//   feed_i : high when the window is active
//   elem_o : vec_i[k_i - lane_i], or zero outside the lane's diagonal / window
module systolic_lane_sel import systolic_pkg::*; #(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned N          = DEF_N,
    parameter int unsigned KW         = 3
) (
    input  logic [N*DATA_WIDTH-1:0] vec_i,
    input  logic [$clog2(N)-1:0]    lane_i,
    input  logic [KW-1:0]           k_i,
    input  logic                    feed_i,
    output logic [DATA_WIDTH-1:0]   elem_o
);

    int sel;

    always_comb begin
        elem_o = '0;
        sel    = int'(k_i) - int'(lane_i);
        if (feed_i && lane_hit(int'(k_i), int'(lane_i), int'(N))) begin
            elem_o = vec_i[sel*DATA_WIDTH +: DATA_WIDTH];
        end
    end

endmodule

// File: rtl/systolic_feeder.sv
// Feeder for the 4x4 systolic array: loads A then B one row per beat, then
// pulses clear, streams the diagonally skewed operands for 2N-1 cycles and
// pulses feed_done.
//   clk_i : clock, rising edge
//   rst_i : synchronous active-high reset
//   bus   : row-beat handshake in, skewed lanes and job strobes out
module systolic_feeder import systolic_pkg::*; #(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned N          = DEF_N
) (
    input  logic               clk_i,
    input  logic               rst_i,
    systolic_feeder_if.slave   bus
);

    localparam int unsigned RowW  = N * DATA_WIDTH;
    localparam int unsigned BeatW = $clog2(N);
    localparam int unsigned KW    = $clog2(FEED_LEN);

    localparam logic [BeatW-1:0] BeatLast = BeatW'(N - 1);
    localparam logic [KW-1:0]    KLast    = KW'(FEED_LEN - 1);

    feeder_state_e    state_q, state_d;
    logic [BeatW-1:0] beat_q, beat_d;
    logic [KW-1:0]    k_q, k_d;
    logic [RowW-1:0]  a_q [N];
    logic [RowW-1:0]  b_q [N];
    logic [RowW-1:0]  b_col [N];
    logic [RowW-1:0]  left_d, up_d, left_q, up_q;
    logic             accept, feed_d;

    assign bus.in_ready_o  = (state_q == StLoadA) || (state_q == StLoadB);
    assign bus.clear_o     = (state_q == StClear);
    assign bus.valid_o     = (state_q == StFeed);
    assign bus.feed_done_o = (state_q == StDone);
    assign bus.busy_o      = bus.clear_o || bus.valid_o || bus.feed_done_o;
    assign bus.left_o      = left_q;
    assign bus.up_o        = up_q;

    assign accept = bus.in_valid_i && bus.in_ready_o;

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        k_d     = k_q;
        case (state_q)
            StLoadA: begin
                if (accept) begin
                    beat_d = beat_q + 1'b1;
                    if (beat_q == BeatLast) begin
                        state_d = StLoadB;
                        beat_d  = '0;
                    end
                end
            end
            StLoadB: begin
                if (accept) begin
                    beat_d = beat_q + 1'b1;
                    if (beat_q == BeatLast) begin
                        state_d = StClear;
                        beat_d  = '0;
                    end
                end
            end
            StClear: begin
                state_d = StFeed;
                k_d     = '0;
            end
            StFeed: begin
                if (k_q == KLast) begin
                    state_d = StDone;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            StDone:  state_d = StLoadA;
            default: state_d = StLoadA;
        endcase
    end

    // Lanes are computed from next-state so the registered outputs line up
    // with valid_o: the CLEAR cycle prepares the k=0 frame.
    assign feed_d = (state_d == StFeed);

    // B arrives by rows; top lanes need columns.
    always_comb begin
        for (int c = 0; c < int'(N); c++) begin
            b_col[c] = '0;
            for (int i = 0; i < int'(N); i++) begin
                b_col[c][i*DATA_WIDTH +: DATA_WIDTH] = b_q[i][c*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    for (genvar r = 0; r < int'(N); r++) begin : g_lane
        systolic_lane_sel #(
            .DATA_WIDTH (DATA_WIDTH),
            .N          (N),
            .KW         (KW)
        ) u_left (
            .vec_i  (a_q[r]),
            .lane_i (BeatW'(r)),
            .k_i    (k_d),
            .feed_i (feed_d),
            .elem_o (left_d[r*DATA_WIDTH +: DATA_WIDTH])
        );

        systolic_lane_sel #(
            .DATA_WIDTH (DATA_WIDTH),
            .N          (N),
            .KW         (KW)
        ) u_up (
            .vec_i  (b_col[r]),
            .lane_i (BeatW'(r)),
            .k_i    (k_d),
            .feed_i (feed_d),
            .elem_o (up_d[r*DATA_WIDTH +: DATA_WIDTH])
        );
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StLoadA;
            beat_q  <= '0;
            k_q     <= '0;
            left_q  <= '0;
            up_q    <= '0;
            for (int i = 0; i < int'(N); i++) begin
                a_q[i] <= '0;
                b_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            k_q     <= k_d;
            left_q  <= left_d;
            up_q    <= up_d;
            if (accept && (state_q == StLoadA)) a_q[beat_q] <= bus.in_data_i;
            if (accept && (state_q == StLoadB)) b_q[beat_q] <= bus.in_data_i;
        end
    end

endmodule

// File: tb/tb_systolic_feeder.sv
// Scoreboard bench for systolic_feeder: the driver pushes the expected
// clear / feed / done cycles of every job when its last beat is accepted;
// a negedge monitor pops one entry per active output cycle and checks idle
// cycles against reset-like values.
module tb_systolic_feeder;
    import systolic_pkg::*;

    localparam int unsigned DW   = 32;
    localparam int unsigned N    = 4;
    localparam int unsigned RowW = N * DW;

    // ctrl = {in_ready, busy, clear, valid, feed_done}
    typedef struct packed {
        logic [4:0]      ctrl;
        logic [RowW-1:0] left;
        logic [RowW-1:0] up;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    systolic_feeder_if #(.DATA_WIDTH(DW), .N(N)) bus ();

    systolic_feeder #(.DATA_WIDTH(DW), .N(N)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    bit          mon_en   = 1'b0;
    logic [31:0] ma [4][4];
    logic [31:0] mb [4][4];

    task automatic check(input string name, input logic [RowW-1:0] act,
                         input logic [RowW-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [RowW-1:0] row_of(input bit is_b, input int i);
        logic [RowW-1:0] v;
        for (int k = 0; k < 4; k++) v[k*DW +: DW] = is_b ? mb[i][k] : ma[i][k];
        return v;
    endfunction

    // Reference: lane r of left carries A[r][k-r], lane c of up carries B[k-c][c].
    task automatic push_expected();
        exp_t e;
        e.ctrl = 5'b01100;
        e.left = '0;
        e.up   = '0;
        exp_q.push_back(e);
        for (int k = 0; k < 7; k++) begin
            e.ctrl = 5'b01010;
            e.left = '0;
            e.up   = '0;
            for (int l = 0; l < 4; l++) begin
                if (k - l >= 0 && k - l < 4) begin
                    e.left[l*DW +: DW] = ma[l][k-l];
                    e.up[l*DW +: DW]   = mb[k-l][l];
                end
            end
            exp_q.push_back(e);
        end
        e.ctrl = 5'b01001;
        e.left = '0;
        e.up   = '0;
        exp_q.push_back(e);
    endtask

    // Holds valid until the DUT is ready; junk data is shown while it is not.
    task automatic send_beat(input logic [RowW-1:0] row);
        int budget = 0;
        bit done   = 1'b0;
        bus.in_valid_i = 1'b1;
        while (!done) begin
            @(negedge clk);
            if (bus.in_ready_o) begin
                bus.in_data_i = row;
                done = 1'b1;
            end else begin
                bus.in_data_i = {4{32'h0000_DEAD}};
            end
            @(posedge clk);
            #1;
            budget++;
            if (!done && budget > 200) begin
                n_checks++;
                $display("FAIL send_beat_timeout: in_ready_o stayed 0 for %0d cycles, required 1",
                         budget);
                done = 1'b1;
            end
        end
    endtask

    task automatic run_job(input bit gapped, input bit hold);
        for (int i = 0; i < 8; i++) begin
            send_beat(row_of(i >= 4, i % 4));
            if (gapped && i < 7) begin
                bus.in_valid_i = 1'b0;
                repeat ($urandom_range(1, 3)) begin
                    @(posedge clk);
                    #1;
                end
            end
        end
        push_expected();
        if (!hold) bus.in_valid_i = 1'b0;
    endtask

    task automatic wait_drain();
        int budget = 0;
        while (exp_q.size() != 0 && budget < 100) begin
            @(posedge clk);
            #1;
            budget++;
        end
        check("drain_queue_empty", RowW'(exp_q.size()), '0);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
    endtask

    // kind 0: A=1..16, B=I; 1: random; 2: all-ones A, 0x80000001 B
    task automatic set_mats(input int kind);
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                unique case (kind)
                    0: begin
                        ma[i][j] = 32'(i * 4 + j + 1);
                        mb[i][j] = (i == j) ? 32'd1 : 32'd0;
                    end
                    1: begin
                        ma[i][j] = $urandom;
                        mb[i][j] = $urandom;
                    end
                    default: begin
                        ma[i][j] = 32'hFFFF_FFFF;
                        mb[i][j] = 32'h8000_0001;
                    end
                endcase
            end
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            logic [4:0] ctrl;
            exp_t       e;
            ctrl = {bus.in_ready_o, bus.busy_o, bus.clear_o, bus.valid_o, bus.feed_done_o};
            if (bus.busy_o || bus.clear_o || bus.valid_o || bus.feed_done_o) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_activity: ctrl=%b with no job pending", ctrl);
                end else begin
                    e = exp_q.pop_front();
                    check("job_ctrl", RowW'(ctrl), RowW'(e.ctrl));
                    check("job_left", bus.left_o, e.left);
                    check("job_up", bus.up_o, e.up);
                end
            end else begin
                check("idle_ctrl", RowW'(ctrl), RowW'(5'b10000));
                check("idle_lanes", bus.left_o | bus.up_o, '0);
            end
        end
    end

    initial begin
        rst            = 1'b1;
        bus.in_valid_i = 1'b0;
        bus.in_data_i  = '0;
        repeat (2) @(posedge clk);
        #1;
        rst    = 1'b0;
        mon_en = 1'b1;

        // Skew pattern, back-to-back beats.
        set_mats(0);
        run_job(1'b0, 1'b0);
        wait_drain();

        // Same matrices with gaps between beats.
        run_job(1'b1, 1'b0);
        wait_drain();

        // Valid held through the job; next job's row 0 is the first beat after ready.
        set_mats(1);
        run_job(1'b0, 1'b1);
        set_mats(1);
        run_job(1'b0, 1'b0);
        wait_drain();

        // Reset during k=3 of a feed; the next job must reload everything.
        set_mats(1);
        run_job(1'b0, 1'b0);
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        exp_q.delete();
        rst = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        set_mats(1);
        run_job(1'b1, 1'b0);
        wait_drain();

        // Extreme bit patterns pass through unchanged.
        set_mats(2);
        run_job(1'b1, 1'b0);
        wait_drain();

        for (int j = 0; j < 3; j++) begin
            set_mats(1);
            run_job(j[0], 1'b0);
            wait_drain();
        end

        mon_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/systolic_feeder.md
# systolic_feeder

Upstream feeder stage for the 4x4 systolic multiplier array. It accepts the two operand matrices A and B one row per handshake beat and stores them locally. It then drives the array's left and top edges with the diagonally skewed, zero-padded operand streams. It also emits a one-cycle clear before each job and a completion pulse after the last operand has left.

## Interface
- DATA_WIDTH, 32, element width; must equal the array's DATA_WIDTH
- N, 4, matrix dimension; only 4 is supported (matches the array)
- clk_i  input  1  clock; all logic on rising edge
- rst_i  input  1  synchronous, active-high reset
- in_valid_i  input  1  row beat valid
- in_ready_o  output  1  feeder can accept a row beat
- in_data_i  input  N*DATA_WIDTH  one matrix row; element k in bits [k*DATA_WIDTH +: DATA_WIDTH]
- clear_o  output  1  one-cycle pulse to clear array accumulators before a job
- valid_o  output  1  high during the 2N-1 cycle feed window
- left_o  output  N*DATA_WIDTH  lane r drives array row r's left input (left_i_0/4/8/12)
- up_o  output  N*DATA_WIDTH  lane c drives array column c's top input (up_i_0..3)
- feed_done_o  output  1  one-cycle pulse after the feed window
- busy_o  output  1  high in CLEAR, FEED and DONE states

## Operation
- One clock (clk_i); reset is synchronous and active-high (rst_i).
- State machine states are LOAD_A, LOAD_B, CLEAR, FEED and DONE.
- **Reset:**
  - state goes to LOAD_A; beat and feed counters go to 0.
  - in_ready_o=1; clear_o, valid_o, feed_done_o and busy_o are 0.
  - left_o and up_o are all zeros; stored matrices are discarded.
- **LOAD_A:**
  - in_ready_o=1.
  - Each cycle with in_valid_i&&in_ready_o stores in_data_i as A row `beat`; beat counts 0..N-1.
  - After row N-1 is accepted, go to LOAD_B with beat=0.
- **LOAD_B:** same handshake. Beat i stores B row i, so column c of B is element c of every row. After row N-1, go to CLEAR.
- **CLEAR:** one cycle. clear_o=1, in_ready_o=0. Go to FEED with k=0.
- **FEED:** 2N-1=7 cycles, k=0..6, valid_o=1, in_ready_o=0.
  - left lane r = A[r][k-r] when 0<=k-r<N, else 0.
  - up lane c = B[k-c][c] when 0<=k-c<N, else 0.
  - After k=6, go to DONE.
- **DONE:** one cycle. feed_done_o=1. Go to LOAD_A.
- Outside FEED, left_o and up_o are all zeros.
- in_valid_i is ignored whenever in_ready_o=0; no beat is lost or counted.
- No arithmetic is performed. Elements pass through bit-exact, with no sign or width change.
- No output backpressure: the array consumes every cycle.

## Timing
- All outputs are registered. They change only on the rising edge of clk_i.
- in_ready_o is a function of the registered state only, with no combinational path from in_valid_i.
- If the last B beat is accepted at edge E, then:
  - clear_o is high for the cycle after E.
  - valid_o is high for the next 7 cycles.
  - feed_done_o is high for the cycle after that.
  - in_ready_o returns to 1 in the cycle after feed_done_o.
- Minimum job period is 8 load cycles + 1 + 7 + 1 = 17 cycles.
- The array needs a further 2N-2 cycles after the window before PE15 holds its final sum. Counting that drain is the consumer's job, not this block's.
- rst_i mid-operation, in any state, takes effect at the next edge:
  - outputs go to their reset values in the following cycle.
  - a new job requires 8 fresh beats.
- rst_i together with in_valid_i: reset wins and the beat is not stored.

## Structure
- Shared package systolic_pkg holds:
  - default DATA_WIDTH, N, and FEED_LEN = 2*N-1.
  - the feeder state enum.
  - the lane-select helper function.
  The array and its result collector use the same package.
- Sub-module systolic_lane_sel instanced 2N times, once per lane.
  - Inputs: a stored row or column vector, the lane index, k and the FEED flag.
  - Output: the lane element, or zero.
  - The top level holds the FSM, counters and storage.

## Test plan
- **Reset behaviour:** hold rst_i for 2 cycles -> in_ready_o=1, valid_o=0, clear_o=0, feed_done_o=0, left_o=0, up_o=0.
- **Skew pattern:** A=1..16 row-major, B=identity, 8 back-to-back beats ->
  - clear_o exactly one cycle.
  - k=0: left={1,0,0,0}, up={1,0,0,0}.
  - k=3: left={4,7,10,13}, up={0,0,0,0}.
  - k=6: left={0,0,0,16}, up={0,0,0,1}.
  - feed_done_o one cycle after k=6.
- **Gapped input:** same matrices with in_valid_i low for 1-3 random cycles between beats -> identical feed sequence; exactly 8 accepted beats.
- **Input during job:** in_valid_i held high through CLEAR/FEED/DONE with data 0xDEAD -> nothing accepted. The first beat after in_ready_o rises becomes next A row 0.
- **Reset mid-feed:** assert rst_i at k=3 -> next cycle all outputs zero and in_ready_o=1. The following job needs 8 new beats and feeds only new data.
- **Width and pass-through:** all elements 0xFFFFFFFF in A, 0x80000001 in B -> lanes carry those exact values in their skew slots and zeros elsewhere.
